// File: rtl/uart_alu_ctrl.sv
// Sequences UART RX bytes (A, B, opcode) into the ALU and hands the result to UART TX.
// Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic [NB_DATA-1:0] alu_result,
  input  logic               tx_done_tick,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  output logic               busy,
  output logic               rx_drop,
  output logic               timeout
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t               r_state, w_next;
  logic [NB_DATA-1:0]   r_a, r_b, r_txd;
  logic [NB_OP-1:0]     r_op;
  logic                 w_expire;

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_A;
    else       r_state <= w_next;
  end

  // A byte arriving in the same cycle as expiry wins: rx is tested first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_A:  if (rx_done_tick) w_next = WAIT_B;
      WAIT_B:  if (rx_done_tick) w_next = WAIT_OP;
               else if (w_expire) w_next = WAIT_A;
      WAIT_OP: if (rx_done_tick) w_next = EXEC;
               else if (w_expire) w_next = WAIT_A;
      EXEC:    w_next = SEND;
      SEND:    w_next = WAIT_TX;
      WAIT_TX: if (tx_done_tick) w_next = WAIT_A;
      default: w_next = WAIT_A;
    endcase
  end

  always_comb begin
    busy     = (r_state != WAIT_A);
    tx_start = (r_state == SEND);
    rx_drop  = rx_done_tick &&
               ((r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX));
    timeout  = w_expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_txd <= '0;
    end else begin
      if (rx_done_tick) begin
        case (r_state)
          WAIT_A:  r_a  <= rx_data;
          WAIT_B:  r_b  <= rx_data;
          WAIT_OP: r_op <= rx_data[NB_OP-1:0];
          default: ;
        endcase
      end
      if (r_state == EXEC) r_txd <= alu_result;
    end
  end

  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_op  = r_op;
  assign tx_data = r_txd;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] r_tcnt;
  logic          w_collecting;

  assign w_collecting = (r_state == WAIT_B) || (r_state == WAIT_OP);
  assign w_expire     = w_collecting && s_tick && !rx_done_tick && (r_tcnt == LAST);

  // Held at zero outside the collecting states so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset)                                       r_tcnt <= '0;
    else if (!w_collecting || rx_done_tick || w_expire) r_tcnt <= '0;
    else if (s_tick)                                 r_tcnt <= r_tcnt + 1'b1;
  end
`else
  logic w_unused;
  assign w_expire = 1'b0;
  assign w_unused = s_tick | (TIMEOUT_TICKS == 0);
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: transaction-level model checked every cycle plus literal checks.
module tb_uart_alu_ctrl;
  localparam int TT = 16;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, s_tick, rx_done_tick, tx_done_tick;
  logic [7:0] rx_data, alu_result, alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, rx_drop, timeout;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_TICKS(TT)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx_done_tick(rx_done_tick),
    .rx_data(rx_data), .alu_result(alu_result), .tx_done_tick(tx_done_tick),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .rx_drop(rx_drop), .timeout(timeout)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: count of operand bytes collected, then a post-opcode
  // phase (1 = result captured next edge, 2 = start cycle, 3 = awaiting tx done).
  int         m_nbytes = 0, m_after = 0, m_ticks = 0;
  logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
  logic [5:0] m_op = 0;

  function automatic bit m_expire();
    return TO_EN && (m_nbytes > 0) && (m_after == 0) && s_tick && !rx_done_tick && (m_ticks == TT - 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_nbytes = 0; m_after = 0; m_ticks = 0;
      m_a = 0; m_b = 0; m_op = 0; m_txd = 0;
    end else if (m_after == 0) begin
      if (rx_done_tick) begin
        m_ticks = 0;
        if (m_nbytes == 0)      m_a  = rx_data;
        else if (m_nbytes == 1) m_b  = rx_data;
        else                    m_op = rx_data[5:0];
        if (m_nbytes == 2) begin m_nbytes = 0; m_after = 1; end
        else m_nbytes++;
      end else if (m_expire()) begin
        m_nbytes = 0; m_ticks = 0;
      end else if (m_nbytes > 0 && s_tick) m_ticks++;
    end else if (m_after == 1) begin
      m_txd = alu_f(m_a, m_b, m_op);
      m_after = 2;
    end else if (m_after == 2) m_after = 3;
    else if (tx_done_tick) m_after = 0;
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("m_alu_a",    alu_a,    m_a);
      cmp("m_alu_b",    alu_b,    m_b);
      cmp("m_alu_op",   alu_op,   m_op);
      cmp("m_tx_data",  tx_data,  m_txd);
      cmp("m_tx_start", tx_start, m_after == 2);
      cmp("m_busy",     busy,     (m_nbytes != 0) || (m_after != 0));
      cmp("m_rx_drop",  rx_drop,  rx_done_tick && (m_after != 0));
      cmp("m_timeout",  timeout,  m_expire());
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done_tick = 1'b1;
    cyc();
    rx_done_tick = 1'b0;
  endtask

  task automatic tx_done();
    tx_done_tick = 1'b1;
    cyc();
    tx_done_tick = 1'b0;
  endtask

  // Called right after the opcode edge; measures cycles to the start pulse.
  task automatic wait_start(output int lat);
    lat = 1;
    while (!tx_start && lat < 6) begin cyc(); lat++; end
  endtask

  int lat;

  initial begin
    reset = 1'b1; s_tick = 1'b0; rx_done_tick = 1'b0; tx_done_tick = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; started = 1'b1;
    cmp("rst_alu_a", alu_a, 8'h00);
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_tx_start", tx_start, 1'b0);
    cmp("rst_tx_data", tx_data, 8'h00);

    // Stray tx_done in WAIT_A has no effect.
    tx_done();
    cmp("stray_txdone_busy", busy, 1'b0);

    // Basic ADD sequence.
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    wait_start(lat);
    cmp("basic_latency", lat, 2);
    cmp("basic_tx_start", tx_start, 1'b1);
    cmp("basic_tx_data", tx_data, 8'h08);
    cmp("basic_alu_a", alu_a, 8'h05);
    cmp("basic_alu_b", alu_b, 8'h03);
    cmp("basic_alu_op", alu_op, 6'h20);
    cyc();
    cmp("basic_start_single", tx_start, 1'b0);
    cmp("basic_busy_wait", busy, 1'b1);

    // Drop while waiting for the transmitter.
    rx_data = 8'hAA; rx_done_tick = 1'b1;
    #2 cmp("drop_pulse", rx_drop, 1'b1);
    cyc();
    rx_done_tick = 1'b0;
    cmp("drop_alu_a_kept", alu_a, 8'h05);
    cmp("drop_tx_data_kept", tx_data, 8'h08);
    repeat (3) cyc();
    cmp("busy_before_done", busy, 1'b1);
    tx_done();
    cmp("done_busy_low", busy, 1'b0);

    // Next byte after completion loads A; opcode upper bits masked.
    send_byte(8'h11);
    cmp("after_drop_alu_a", alu_a, 8'h11);
    send_byte(8'h04); send_byte(8'hE2);
    cmp("mask_alu_op", alu_op, 6'h22);
    wait_start(lat);
    cmp("mask_tx_data", tx_data, 8'h0D);
    cyc();
    tx_done();

    // Reset mid-sequence.
    send_byte(8'h05); send_byte(8'h03);
    reset = 1'b1; cyc(); reset = 1'b0;
    cmp("midrst_alu_a", alu_a, 8'h00);
    cmp("midrst_alu_b", alu_b, 8'h00);
    cmp("midrst_busy", busy, 1'b0);
    send_byte(8'h07); send_byte(8'h02); send_byte(8'h22);
    wait_start(lat);
    cmp("midrst_latency", lat, 2);
    cmp("midrst_tx_data", tx_data, 8'h05);
    cyc();
    tx_done();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // Expiry on the 16th tick.
    send_byte(8'h05);
    s_tick = 1'b1;
    repeat (TT - 1) cyc();
    #2 cmp("to_pulse", timeout, 1'b1);
    cyc();
    s_tick = 1'b0;
    cmp("to_busy", busy, 1'b0);
    cmp("to_alu_a_kept", alu_a, 8'h05);

    // Byte on the 16th tick wins over expiry.
    send_byte(8'h09);
    s_tick = 1'b1;
    repeat (TT - 1) cyc();
    rx_data = 8'h03; rx_done_tick = 1'b1;
    #2 cmp("to_race_no_pulse", timeout, 1'b0);
    cyc();
    rx_done_tick = 1'b0; s_tick = 1'b0;
    cmp("to_race_busy", busy, 1'b1);
    cmp("to_race_alu_b", alu_b, 8'h03);
    send_byte(8'h24);
    wait_start(lat);
    cmp("to_race_tx_data", tx_data, 8'h01);
    cyc();
    tx_done();
`else
    // No timeout hardware: partial sequence waits indefinitely.
    send_byte(8'h05);
    s_tick = 1'b1;
    repeat (10000) cyc();
    s_tick = 1'b0;
    cmp("noto_timeout", timeout, 1'b0);
    cmp("noto_busy", busy, 1'b1);
    send_byte(8'h03); send_byte(8'h25);
    wait_start(lat);
    cmp("noto_tx_data", tx_data, 8'h07);
    cyc();
    tx_done();
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
